// File: rtl/cherry_eat_detector.sv
// cherry_eat_detector
// Watches the per-pixel snake-head and cherry flags across a raster frame and
// decides whether the head overlapped the cherry. The decision is taken at the
// next frame start and produces a one-cycle eat/grow pulse plus a BCD score
// increment. A frame-based cooldown after each eat keeps the stale cherry image
// from re-triggering before the renderer has drawn the relocated cherry.
//
// state | meaning
// ------+------------------------------------------------------------------
// SCAN  | counting aligned head/cherry overlap; eat decision at frame start
// COOL  | post-eat cooldown; overlap held at 0, whole frames counted down
module cherry_eat_detector #(
  parameter int HEAD_DLY        = 2,
  parameter int MIN_OVERLAP     = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [8:0] pixel_y,
  input  logic       video_on,
  input  logic       game_active,
  input  logic       snake_head,
  input  logic       cherry,
  output logic       eating_cherry,
  output logic       grow_req,
  output logic [7:0] score_bcd,
  output logic [7:0] overlap_dbg
);

  typedef enum logic {
    SCAN = 1'b0,
    COOL = 1'b1
  } state_t;

  localparam logic [7:0] MIN_OVL   = 8'(MIN_OVERLAP);
  localparam logic [3:0] COOL_INIT = 4'(COOLDOWN_FRAMES);

  state_t     state, state_nxt;
  logic [3:0] cfr, cfr_nxt;
  logic [7:0] ovl, ovl_nxt;
  logic [7:0] dbg_nxt;
  logic [7:0] score_nxt;
  logic       eat_q, eat_nxt;
  logic       fs_q;
  logic       frame_start;
  logic       fs_edge;
  logic       head_a;
  logic       hit;

  // BCD increment of a two-digit score, sticking at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Head alignment: the cherry flag arrives registered, so the head flag is
  // delayed by the same number of cycles before the two are compared.
  generate
    if (HEAD_DLY == 0) begin : g_head_direct
      assign head_a = snake_head;
    end else begin : g_head_dly
      logic [HEAD_DLY-1:0] head_sr;

      // Shift register delaying snake_head by HEAD_DLY cycles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          head_sr <= '0;
        end else begin
          head_sr[0] <= snake_head;
          for (int i = 1; i < HEAD_DLY; i++) begin
            head_sr[i] <= head_sr[i-1];
          end
        end
      end

      assign head_a = head_sr[HEAD_DLY-1];
    end
  endgenerate

  // A stalled pixel clock can hold (0,0) for several cycles; only the first
  // cycle of such a run is treated as the frame start.
  assign frame_start = (pixel_x == 10'd0) && (pixel_y == 9'd0);
  assign fs_edge     = frame_start && !fs_q;
  assign hit         = video_on && head_a && cherry;

  // Previous-cycle frame-start flag for the edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_q <= 1'b0;
    end else begin
      fs_q <= frame_start;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      cfr         <= '0;
      ovl         <= '0;
      overlap_dbg <= '0;
      score_bcd   <= '0;
      eat_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cfr         <= cfr_nxt;
      ovl         <= ovl_nxt;
      overlap_dbg <= dbg_nxt;
      score_bcd   <= score_nxt;
      eat_q       <= eat_nxt;
    end
  end

  // Next-state, overlap counting, eat decision and cooldown countdown.
  // The frame-start action wins over an overlap increment in the same cycle,
  // so the pixel at (0,0) never counts.
  always_comb begin
    state_nxt = state;
    cfr_nxt   = cfr;
    ovl_nxt   = ovl;
    dbg_nxt   = overlap_dbg;
    score_nxt = score_bcd;
    eat_nxt   = 1'b0;
    case (state)
      SCAN: begin
        if (fs_edge) begin
          dbg_nxt = ovl;
          ovl_nxt = '0;
          if (game_active && (ovl >= MIN_OVL)) begin
            eat_nxt   = 1'b1;
            score_nxt = bcd_inc(score_bcd);
            cfr_nxt   = COOL_INIT;
            state_nxt = COOL;
          end
        end else if (hit && (ovl != 8'hFF)) begin
          ovl_nxt = ovl + 8'd1;
        end
      end
      COOL: begin
        ovl_nxt = '0;
        if (fs_edge) begin
          // Terminal count: this frame start ends the cooldown and, with ovl
          // already 0, counting resumes for the frame that starts now.
          if (cfr == 4'd1) begin
            cfr_nxt   = '0;
            state_nxt = SCAN;
          end else begin
            cfr_nxt = cfr - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

  assign eating_cherry = eat_q;
  assign grow_req      = eat_q;

endmodule

// File: tb/tb_cherry_eat_detector.sv
// Testbench for cherry_eat_detector: frame-level vector table, directed
// multi-cycle sequences (cooldown, score saturation, reset) and a randomized
// phase, all checked every cycle against a behavioural frame/overlap model.
module tb_cherry_eat_detector;

  localparam int HEAD_DLY = 2;
  localparam int MIN_OVL  = 4;
  localparam int COOL_FR  = 2;

  logic       clk;
  logic       reset;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       video_on;
  logic       game_active;
  logic       snake_head;
  logic       cherry;
  logic       eating_cherry;
  logic       grow_req;
  logic [7:0] score_bcd;
  logic [7:0] overlap_dbg;
  logic       eating_cherry0;
  logic       grow_req0;
  logic [7:0] score_bcd0;
  logic [7:0] overlap_dbg0;

  int n_tests = 0;
  int n_fail  = 0;

  cherry_eat_detector #(
    .HEAD_DLY(HEAD_DLY), .MIN_OVERLAP(MIN_OVL), .COOLDOWN_FRAMES(COOL_FR)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .game_active(game_active), .snake_head(snake_head),
    .cherry(cherry), .eating_cherry(eating_cherry), .grow_req(grow_req),
    .score_bcd(score_bcd), .overlap_dbg(overlap_dbg)
  );

  // Same design without head alignment, to show the delay line matters.
  cherry_eat_detector #(
    .HEAD_DLY(0), .MIN_OVERLAP(MIN_OVL), .COOLDOWN_FRAMES(COOL_FR)
  ) dut_nd (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .game_active(game_active), .snake_head(snake_head),
    .cherry(cherry), .eating_cherry(eating_cherry0), .grow_req(grow_req0),
    .score_bcd(score_bcd0), .overlap_dbg(overlap_dbg0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  int m_count;      // overlapping pixels seen this frame
  int m_cool_left;  // whole frames of cooldown remaining (0 = scanning)
  int m_score;      // decimal score 0..99
  int m_dbg;
  bit m_pulse;
  bit m_prev_fs;
  bit m_hist[$];    // past snake_head values, newest first

  task automatic model_reset();
    m_count = 0; m_cool_left = 0; m_score = 0; m_dbg = 0;
    m_pulse = 0; m_prev_fs = 0;
    m_hist = {};
    repeat (8) m_hist.push_back(1'b0);
  endtask

  task automatic model_update(input logic [9:0] x, input logic [8:0] y,
                              input bit vo, input bit hd, input bit ch, input bit ga);
    bit fs_now, first, head_al;
    fs_now  = (x == 0) && (y == 0);
    first   = fs_now && !m_prev_fs;
    head_al = m_hist[HEAD_DLY-1];
    m_hist.push_front(hd);
    void'(m_hist.pop_back());
    m_pulse = 0;
    if (m_cool_left == 0) begin
      if (first) begin
        m_dbg = m_count;
        if (ga && m_count >= MIN_OVL) begin
          m_pulse = 1;
          m_score = (m_score < 99) ? m_score + 1 : 99;
          m_cool_left = COOL_FR;
        end
        m_count = 0;
      end else if (vo && head_al && ch) begin
        m_count = (m_count < 255) ? m_count + 1 : 255;
      end
    end else if (first) begin
      m_cool_left = m_cool_left - 1;
    end
    m_prev_fs = fs_now;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [8:0] y,
                      input bit vo, input bit hd, input bit ch, input bit ga);
    logic [7:0] exp_bcd;
    pixel_x = x; pixel_y = y; video_on = vo;
    snake_head = hd; cherry = ch; game_active = ga;
    @(posedge clk);
    model_update(x, y, vo, hd, ch, ga);
    #1;
    exp_bcd = {4'(m_score / 10), 4'(m_score % 10)};
    chk("cyc", {14'd0, eating_cherry, grow_req, score_bcd, overlap_dbg},
        {14'd0, m_pulse, m_pulse, exp_bcd, 8'(m_dbg)});
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b0;
    #1;
    chk(name, {16'd0, eating_cherry, grow_req, score_bcd, overlap_dbg}, 32'd0);
    model_reset();
    pixel_x = 10'd5; pixel_y = 9'd5; video_on = 1'b0;
    snake_head = 1'b0; cherry = 1'b0; game_active = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic frame_start(input bit ga);
    step(10'd0, 9'd0, 1'b1, 1'b0, 1'b0, ga);
  endtask

  // Body of a frame on row 0: head leads cherry by 2 cycles, n aligned pixels.
  task automatic frame_body(input int n);
    int len;
    len = (n + 6 > 10) ? n + 6 : 10;
    for (int k = 1; k <= len; k++) begin
      step(10'(k), 9'd0, 1'b1, (k >= 2) && (k < 2 + n), (k >= 4) && (k < 4 + n), 1'b1);
    end
  endtask

  typedef struct {
    bit ga;
    bit exp_pulse;
    int exp_score;
    int exp_dbg;
    int n_body;
  } vec_t;

  vec_t tbl[13];
  int   pulses;
  logic [3:0] mask;

  initial begin
    // {game_active at frame start, expected pulse, score, overlap_dbg, body overlap}
    tbl[0]  = '{1, 0, 'h00,   0,  81};
    tbl[1]  = '{1, 1, 'h01,  81,   3};
    tbl[2]  = '{1, 0, 'h01,  81,   3};
    tbl[3]  = '{1, 0, 'h01,  81,   3};
    tbl[4]  = '{1, 0, 'h01,   3,   4};
    tbl[5]  = '{1, 1, 'h02,   4,  10};
    tbl[6]  = '{1, 0, 'h02,   4,  10};
    tbl[7]  = '{1, 0, 'h02,   4,  10};
    tbl[8]  = '{0, 0, 'h02,  10, 300};
    tbl[9]  = '{1, 1, 'h03, 255,   5};
    tbl[10] = '{1, 0, 'h03, 255,   5};
    tbl[11] = '{0, 0, 'h03, 255,   5};
    tbl[12] = '{1, 1, 'h04,   5,   0};

    reset = 1'b1;
    pixel_x = 10'd5; pixel_y = 9'd5; video_on = 1'b0;
    snake_head = 1'b0; cherry = 1'b0; game_active = 1'b1;
    model_reset();
    #3;
    apply_reset("rst_init");

    // Frame-level vector table: eat, sub-threshold, threshold, cooldown,
    // game_active low, saturation of the overlap counter.
    for (int i = 0; i < 13; i++) begin
      frame_start(tbl[i].ga);
      chk($sformatf("tbl%0d_pulse", i), {30'd0, eating_cherry, grow_req},
          {30'd0, tbl[i].exp_pulse, tbl[i].exp_pulse});
      chk($sformatf("tbl%0d_score", i), {24'd0, score_bcd}, 32'(tbl[i].exp_score));
      chk($sformatf("tbl%0d_dbg", i), {24'd0, overlap_dbg}, 32'(tbl[i].exp_dbg));
      if (i == 1) begin
        // Without alignment only 79 of the 81 pixels coincide.
        chk("noalign", {14'd0, eating_cherry0, grow_req0, score_bcd0, overlap_dbg0},
            {14'd0, 1'b1, 1'b1, 8'h01, 8'd79});
      end
      if (i == 2) chk("pulse_width", {31'd0, eating_cherry}, 32'd0);
      frame_body(tbl[i].n_body);
    end

    // Overlap every frame for 5 frames: pulses only at frame 2 and 5 starts.
    apply_reset("rst_t3");
    frame_start(1'b1);
    frame_body(10);
    mask = '0;
    for (int f = 2; f <= 5; f++) begin
      frame_start(1'b1);
      mask[f-2] = eating_cherry;
      frame_body(10);
    end
    chk("cool_pulses", {28'd0, mask}, 32'b1001);
    chk("cool_score", {24'd0, score_bcd}, 32'h02);

    // 100 eats: score saturates at 99, the 100th eat still pulses.
    apply_reset("rst_t4");
    frame_start(1'b1);
    frame_body(4);
    pulses = 0;
    for (int f = 0; f < 400; f++) begin
      frame_start(1'b1);
      if (eating_cherry === 1'b1) begin
        pulses++;
        if (pulses == 99) chk("score99", {24'd0, score_bcd}, 32'h99);
      end
      if (pulses == 100) break;
      frame_body(4);
    end
    chk("eat100", pulses, 100);
    chk("sat_score", {24'd0, score_bcd}, 32'h99);
    chk("sat_pulse", {31'd0, eating_cherry}, 32'd1);

    // Reset during the pulse / cooldown, then reset mid-frame with ovl=50.
    apply_reset("rst_cool");
    frame_start(1'b1);
    frame_body(50);
    step(10'd400, 9'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_reset("rst_frame");
    frame_start(1'b1);
    chk("post_rst_pulse", {31'd0, eating_cherry}, 32'd0);
    chk("post_rst_dbg", {24'd0, overlap_dbg}, 32'd0);

    // Randomized phase on a tiny raster so frame starts (and stalls) are frequent.
    for (int i = 0; i < 3000; i++) begin
      step(10'($urandom_range(0, 3)), 9'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
